// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm -- multi-cycle control unit for a small MIPS subset
// (addu, subu, ori, lw, sw, beq, lui, j, jal).
//
// Each instruction is walked through IF -> DCD -> EXE -> MEM -> WB (or BR for
// beq). The unit drives the datapath write enables and the mux selects.
// All outputs are decoded combinationally from the current state and the
// op/funct fields of the instruction register.
//
// Parameters:
//   ILLEGAL_TRAP  1: unknown op/funct parks the FSM in HALT until reset
//                 0: unknown instruction retires as a NOP
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high; returns FSM to IF
//   op       in   IR[31:26]
//   funct    in   IR[5:0], meaningful only for op == 6'h00
//   zero     in   ALU zero flag, used in BR
//   pc_wr    out  PC write enable
//   ir_wr    out  IR write enable
//   reg_wr   out  register file write enable
//   mem_wr   out  data memory write enable
//   reg_dst  out  00 rt, 01 rd, 10 r31
//   wd_sel   out  00 ALU, 01 memory data, 10 PC (already PC+4)
//   alu_src  out  0 register B, 1 extended immediate
//   alu_op   out  00 add, 01 sub, 10 or, 11 lui shift
//   ext_op   out  00 zero-ext, 01 sign-ext, 10 imm<<16
//   npc_op   out  00 PC+4, 01 branch target, 10 jump target
//   done     out  pulses in the last state of each instruction
//   illegal  out  high while parked in HALT
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       mem_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [1:0] ext_op,
    output logic [1:0] npc_op,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_DCD  = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_BR   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    state_t state_q, state_d;

    logic is_addu_s, is_subu_s, is_rtype_s, is_ori_s, is_lui_s;
    logic is_lw_s, is_sw_s, is_beq_s, is_j_s, is_jal_s, is_legal_s;

    logic       pc_wr_s, ir_wr_s, reg_wr_s, mem_wr_s, alu_src_s, done_s;
    logic [1:0] reg_dst_s, wd_sel_s, alu_op_s, ext_op_s, npc_op_s;

    // Instruction decode is re-evaluated every cycle; the datapath keeps IR stable.
    assign is_addu_s  = (op == OP_RTYPE) && (funct == FN_ADDU);
    assign is_subu_s  = (op == OP_RTYPE) && (funct == FN_SUBU);
    assign is_rtype_s = is_addu_s || is_subu_s;
    assign is_ori_s   = (op == OP_ORI);
    assign is_lui_s   = (op == OP_LUI);
    assign is_lw_s    = (op == OP_LW);
    assign is_sw_s    = (op == OP_SW);
    assign is_beq_s   = (op == OP_BEQ);
    assign is_j_s     = (op == OP_J);
    assign is_jal_s   = (op == OP_JAL);
    assign is_legal_s = is_rtype_s || is_ori_s || is_lui_s || is_lw_s || is_sw_s
                        || is_beq_s || is_j_s || is_jal_s;

    // State register; reset always lands in IF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode from current state and instruction fields.
    always_comb begin
        state_d   = S_IF;
        pc_wr_s   = 1'b0;
        ir_wr_s   = 1'b0;
        reg_wr_s  = 1'b0;
        mem_wr_s  = 1'b0;
        reg_dst_s = 2'b00;
        wd_sel_s  = 2'b00;
        alu_src_s = 1'b0;
        alu_op_s  = 2'b00;
        ext_op_s  = 2'b00;
        npc_op_s  = 2'b00;
        done_s    = 1'b0;

        case (state_q)
            S_IF: begin
                pc_wr_s  = 1'b1;
                ir_wr_s  = 1'b1;
                npc_op_s = 2'b00;
                state_d  = S_DCD;
            end
            S_DCD: begin
                if (is_j_s || is_jal_s) begin
                    pc_wr_s  = 1'b1;
                    npc_op_s = 2'b10;
                    done_s   = 1'b1;
                    // jal links PC+4 into r31 in the same cycle as the jump
                    if (is_jal_s) begin
                        reg_wr_s  = 1'b1;
                        reg_dst_s = 2'b10;
                        wd_sel_s  = 2'b10;
                    end else begin
                        reg_wr_s  = 1'b0;
                    end
                    state_d = S_IF;
                end else if (is_beq_s) begin
                    state_d = S_BR;
                end else if (is_legal_s) begin
                    state_d = S_EXE;
                end else if (ILLEGAL_TRAP) begin
                    state_d = S_HALT;
                end else begin
                    // Unknown instruction retires as a NOP
                    done_s  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXE: begin
                if (is_rtype_s) begin
                    alu_op_s  = is_subu_s ? 2'b01 : 2'b00;
                    alu_src_s = 1'b0;
                end else if (is_ori_s) begin
                    alu_op_s  = 2'b10;
                    alu_src_s = 1'b1;
                    ext_op_s  = 2'b00;
                end else if (is_lui_s) begin
                    alu_op_s  = 2'b11;
                    alu_src_s = 1'b1;
                    ext_op_s  = 2'b10;
                end else if (is_lw_s || is_sw_s) begin
                    alu_op_s  = 2'b00;
                    alu_src_s = 1'b1;
                    ext_op_s  = 2'b01;
                end else begin
                    alu_op_s  = 2'b00;
                end
                state_d = (is_lw_s || is_sw_s) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (is_sw_s) begin
                    mem_wr_s = 1'b1;
                    done_s   = 1'b1;
                    state_d  = S_IF;
                end else if (is_lw_s) begin
                    state_d  = S_WB;
                end else begin
                    state_d  = S_IF;
                end
            end
            S_WB: begin
                reg_wr_s = 1'b1;
                done_s   = 1'b1;
                if (is_rtype_s) begin
                    reg_dst_s = 2'b01;
                    wd_sel_s  = 2'b00;
                end else if (is_lw_s) begin
                    reg_dst_s = 2'b00;
                    wd_sel_s  = 2'b01;
                end else begin
                    reg_dst_s = 2'b00;
                    wd_sel_s  = 2'b00;
                end
                state_d = S_IF;
            end
            S_BR: begin
                alu_op_s  = 2'b01;
                alu_src_s = 1'b0;
                npc_op_s  = 2'b01;
                // Branch is taken only when the subtract compares equal
                pc_wr_s   = zero;
                done_s    = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // Enables are forced low while reset is held, even though state already reads IF.
    assign pc_wr   = pc_wr_s  & ~reset;
    assign ir_wr   = ir_wr_s  & ~reset;
    assign reg_wr  = reg_wr_s & ~reset;
    assign mem_wr  = mem_wr_s & ~reset;
    assign done    = done_s   & ~reset;
    assign reg_dst = reg_dst_s;
    assign wd_sel  = wd_sel_s;
    assign alu_src = alu_src_s;
    assign alu_op  = alu_op_s;
    assign ext_op  = ext_op_s;
    assign npc_op  = npc_op_s;
    // HALT is only left through reset, so the state itself is the sticky flag
    assign illegal = (state_q == S_HALT) && !reset;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: two instances (NOP and trap handling of illegal
// instructions) share all inputs. Each cycle's stimulus and the expected
// 17-bit output vector of both instances are pushed to a scoreboard queue
// and popped/compared one per clock.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;

    logic       pc_wr0, ir_wr0, reg_wr0, mem_wr0, alu_src0, done0, illegal0;
    logic [1:0] reg_dst0, wd_sel0, alu_op0, ext_op0, npc_op0;
    logic       pc_wr1, ir_wr1, reg_wr1, mem_wr1, alu_src1, done1, illegal1;
    logic [1:0] reg_dst1, wd_sel1, alu_op1, ext_op1, npc_op1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_wr(pc_wr0), .ir_wr(ir_wr0), .reg_wr(reg_wr0), .mem_wr(mem_wr0),
        .reg_dst(reg_dst0), .wd_sel(wd_sel0), .alu_src(alu_src0), .alu_op(alu_op0),
        .ext_op(ext_op0), .npc_op(npc_op0), .done(done0), .illegal(illegal0)
    );

    mc_ctrl_fsm #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_wr(pc_wr1), .ir_wr(ir_wr1), .reg_wr(reg_wr1), .mem_wr(mem_wr1),
        .reg_dst(reg_dst1), .wd_sel(wd_sel1), .alu_src(alu_src1), .alu_op(alu_op1),
        .ext_op(ext_op1), .npc_op(npc_op1), .done(done1), .illegal(illegal1)
    );

    // Vector layout: pc ir rw mw rd[2] wd[2] as ao[2] eo[2] no[2] dn il
    logic [16:0] obs0, obs1;
    assign obs0 = {pc_wr0, ir_wr0, reg_wr0, mem_wr0, reg_dst0, wd_sel0, alu_src0,
                   alu_op0, ext_op0, npc_op0, done0, illegal0};
    assign obs1 = {pc_wr1, ir_wr1, reg_wr1, mem_wr1, reg_dst1, wd_sel1, alu_src1,
                   alu_op1, ext_op1, npc_op1, done1, illegal1};

    function automatic logic [16:0] mk(input logic pc, input logic ir, input logic rw,
                                       input logic mw, input logic [1:0] rd,
                                       input logic [1:0] wd, input logic as_,
                                       input logic [1:0] ao, input logic [1:0] eo,
                                       input logic [1:0] no, input logic dn,
                                       input logic il);
        return {pc, ir, rw, mw, rd, wd, as_, ao, eo, no, dn, il};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [16:0] exp0;
        logic [16:0] exp1;
        logic [63:0] tag;
    } item_t;

    item_t sb[$];

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                   K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8;

    logic [16:0] v_if, v_zero, v_dcd;

    task automatic push(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic [16:0] e0, input logic [16:0] e1, input logic [63:0] tag);
        item_t it;
        it.op = o; it.funct = f; it.zero = z; it.exp0 = e0; it.exp1 = e1; it.tag = tag;
        sb.push_back(it);
    endtask

    // Push one legal instruction; both instances must behave identically.
    task automatic push_instr(input int kind, input logic z);
        logic [5:0] o, f;
        f = 6'h00;
        case (kind)
            K_ADDU: begin o = 6'h00; f = 6'h21; end
            K_SUBU: begin o = 6'h00; f = 6'h23; end
            K_ORI:  o = 6'h0D;
            K_LUI:  o = 6'h0F;
            K_LW:   o = 6'h23;
            K_SW:   o = 6'h2B;
            K_BEQ:  o = 6'h04;
            K_J:    o = 6'h02;
            default: o = 6'h03;
        endcase
        push(o, f, z, v_if, v_if, "IF");
        case (kind)
            K_J: begin
                push(o, f, z, mk(1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0),
                     mk(1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0), "J_DCD");
            end
            K_JAL: begin
                push(o, f, z, mk(1'b1,1'b0,1'b1,1'b0,2'b10,2'b10,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0),
                     mk(1'b1,1'b0,1'b1,1'b0,2'b10,2'b10,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0), "JAL_DCD");
            end
            K_BEQ: begin
                push(o, f, z, v_dcd, v_dcd, "BEQ_DCD");
                push(o, f, z, mk(z,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,2'b01,1'b1,1'b0),
                     mk(z,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,2'b01,1'b1,1'b0), "BEQ_BR");
            end
            K_ADDU, K_SUBU: begin
                logic [16:0] ex;
                ex = mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,
                        (kind == K_SUBU) ? 2'b01 : 2'b00,2'b00,2'b00,1'b0,1'b0);
                push(o, f, z, v_dcd, v_dcd, "R_DCD");
                push(o, f, z, ex, ex, "R_EXE");
                push(o, f, z, mk(1'b0,1'b0,1'b1,1'b0,2'b01,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0),
                     mk(1'b0,1'b0,1'b1,1'b0,2'b01,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0), "R_WB");
            end
            K_ORI, K_LUI: begin
                logic [16:0] ex, wb;
                ex = (kind == K_ORI)
                     ? mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0)
                     : mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b11,2'b10,2'b00,1'b0,1'b0);
                wb = mk(1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0);
                push(o, f, z, v_dcd, v_dcd, "I_DCD");
                push(o, f, z, ex, ex, "I_EXE");
                push(o, f, z, wb, wb, "I_WB");
            end
            default: begin // lw / sw
                logic [16:0] ex, mem, wb;
                ex  = mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,2'b00,1'b0,1'b0);
                mem = (kind == K_SW)
                      ? mk(1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0)
                      : v_zero;
                wb  = mk(1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0);
                push(o, f, z, v_dcd, v_dcd, "M_DCD");
                push(o, f, z, ex, ex, "M_EXE");
                push(o, f, z, mem, mem, "M_MEM");
                if (kind == K_LW) begin
                    push(o, f, z, wb, wb, "LW_WB");
                end
            end
        endcase
    endtask

    // Drain the scoreboard: one item per clock, sampled 1 time unit after the negedge.
    task automatic run_sb();
        item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            op = it.op; funct = it.funct; zero = it.zero;
            #1;
            checks++;
            if (obs0 !== it.exp0) begin
                errors++;
                $display("FAIL %0s trap0: got %b expected %b", it.tag, obs0, it.exp0);
            end
            checks++;
            if (obs1 !== it.exp1) begin
                errors++;
                $display("FAIL %0s trap1: got %b expected %b", it.tag, obs1, it.exp1);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_now(input logic [16:0] e0, input logic [16:0] e1, input logic [63:0] tag);
        checks++;
        if (obs0 !== e0) begin
            errors++;
            $display("FAIL %0s trap0: got %b expected %b", tag, obs0, e0);
        end
        checks++;
        if (obs1 !== e1) begin
            errors++;
            $display("FAIL %0s trap1: got %b expected %b", tag, obs1, e1);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        #1 check_now(v_zero, v_zero, "RST");
        @(negedge clk);
        reset = 1'b0;
        push_instr(K_J, 1'b0);
        run_sb();
    endtask

    task automatic test_reset_mid();
        push(6'h00, 6'h21, 1'b0, v_if, v_if, "MR_IF");
        push(6'h00, 6'h21, 1'b0, v_dcd, v_dcd, "MR_DCD");
        run_sb();
        #1 check_now(v_zero, v_zero, "MR_EXE");
        reset = 1'b1;
        #1 check_now(v_zero, v_zero, "MR_RST");
        @(negedge clk);
        reset = 1'b0;
        push_instr(K_ADDU, 1'b0);
        run_sb();
    endtask

    task automatic test_alu();
        push_instr(K_ADDU, 1'b0);
        push_instr(K_SUBU, 1'b1);
        push_instr(K_ORI, 1'b0);
        push_instr(K_LUI, 1'b0);
        run_sb();
    endtask

    task automatic test_back_to_back();
        push_instr(K_LW, 1'b0);
        push_instr(K_SW, 1'b0);
        push_instr(K_SW, 1'b1);
        push_instr(K_LW, 1'b1);
        run_sb();
    endtask

    task automatic test_branch_jump();
        push_instr(K_BEQ, 1'b1);
        push_instr(K_BEQ, 1'b0);
        push_instr(K_JAL, 1'b0);
        push_instr(K_J, 1'b1);
        push_instr(K_BEQ, 1'b1);
        run_sb();
    endtask

    task automatic test_illegal();
        logic [16:0] nop_dcd, halt_v;
        nop_dcd = mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0);
        halt_v  = mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
        push(6'h3F, 6'h00, 1'b0, v_if, v_if, "IL_IF");
        push(6'h3F, 6'h00, 1'b0, nop_dcd, v_dcd, "IL_DCD");
        for (int i = 0; i < 10; i++) begin
            push(6'h3F, 6'h00, 1'b1, (i % 2 == 0) ? v_if : nop_dcd, halt_v, "IL_HALT");
        end
        run_sb();
        reset = 1'b1;
        #1 check_now(v_zero, v_zero, "IL_RST");
        @(negedge clk);
        reset = 1'b0;
        push_instr(K_ORI, 1'b0);
        run_sb();
    endtask

    initial begin
        v_zero = 17'd0;
        v_dcd  = 17'd0;
        v_if   = mk(1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
        test_reset();
        test_reset_mid();
        test_alu();
        test_back_to_back();
        test_branch_jump();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS-subset control unit.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives the datapath write enables and the select lines of the 2:1 and 3:1 datapath muxes: register-destination (5-bit), write-data (32-bit), ALU-B (32-bit).
- Sits between the instruction register (op/funct fields) and the datapath muxes, PC, register file and data memory.

Parameters:
- ILLEGAL_TRAP, 0, 1 = unknown op/funct enters HALT (sticky) until reset; 0 = unknown instruction retires as a NOP.

Ports:
- clk input 1: system clock, rising edge.
- reset input 1: asynchronous, active-high; forces state to IF.
- op input 6: IR[31:26]; stable from the cycle after IF.
- funct input 6: IR[5:0]; used only when op=000000.
- zero input 1: ALU zero flag, combinational, valid in BR state.
- pc_wr output 1: PC write enable.
- ir_wr output 1: IR write enable.
- reg_wr output 1: register file write enable.
- mem_wr output 1: data memory write enable.
- reg_dst output 2: 00 rt, 01 rd, 10 const 31.
- wd_sel output 2: 00 ALU result, 01 memory data reg, 10 PC (already PC+4).
- alu_src output 1: 0 register B, 1 extended immediate.
- alu_op output 2: 00 add, 01 sub, 10 or, 11 lui-shift.
- ext_op output 2: 00 zero-extend, 01 sign-extend, 10 imm<<16.
- npc_op output 2: 00 PC+4, 01 branch target, 10 jump target.
- done output 1: one-cycle pulse in the final state of each instruction.
- illegal output 1: sticky; set on entry to HALT.

Behaviour:
- States (3-bit): IF=0, DCD=1, EXE=2, MEM=3, WB=4, BR=5, HALT=6. State 7 is unreachable and decodes as IF next.
- Reset (asynchronous, any cycle, including mid-instruction):
  - state=IF, illegal=0.
  - Outputs are combinational from state; all enables are 0 while reset is high.
  - After release, the first edge performs a fetch.
- Supported instructions: addu (0/21h), subu (0/23h), ori (0Dh), lw (23h), sw (2Bh), beq (04h), lui (0Fh), j (02h), jal (03h).
- Outputs are Moore-style: functions of state and op/funct, except pc_wr in BR.
- Unlisted outputs default to 0 / 00.
- IF:
  - pc_wr=1, ir_wr=1, npc_op=00.
  - Next state: DCD.
- DCD:
  - j: pc_wr=1, npc_op=10, done=1; next IF.
  - jal: as j, plus reg_wr=1, reg_dst=10, wd_sel=10; next IF.
  - beq: next BR.
  - Other legal op: next EXE.
  - Illegal op, ILLEGAL_TRAP=0: done=1; next IF.
  - Illegal op, ILLEGAL_TRAP=1: next HALT.
- EXE:
  - addu: alu_op=00, alu_src=0.
  - subu: alu_op=01, alu_src=0.
  - ori: alu_op=10, alu_src=1, ext_op=00.
  - lui: alu_op=11, alu_src=1, ext_op=10.
  - lw/sw: alu_op=00, alu_src=1, ext_op=01.
  - Next state: MEM for lw/sw, otherwise WB.
- MEM:
  - sw: mem_wr=1, done=1; next IF.
  - lw: no writes; next WB.
- WB:
  - reg_wr=1, done=1; next IF.
  - R-type: reg_dst=01, wd_sel=00.
  - ori/lui: reg_dst=00, wd_sel=00.
  - lw: reg_dst=00, wd_sel=01.
- BR:
  - alu_op=01, alu_src=0, npc_op=01, pc_wr=zero, done=1.
  - Next state: IF.
- HALT:
  - All enables 0, illegal=1; remains in HALT until reset.
- CPI: j/jal 2, beq 3, addu/subu/ori/lui/sw 4, lw 5, illegal NOP 2.
- pc_wr, reg_wr and mem_wr are never asserted in the same cycle, except pc_wr+reg_wr for jal in DCD.
- op changes during non-IF states are not permitted by the datapath. The FSM re-decodes op every cycle with no latching.

Test Plan:
- Reset mid-sequence: assert reset during EXE of addu -> same cycle all enables 0; after release, first cycle shows pc_wr=1, ir_wr=1.
- addu (op=0, funct=21h) -> states IF,DCD,EXE,WB; WB shows reg_wr=1, reg_dst=01, wd_sel=00; done pulses once on cycle 4.
- lw (23h) then sw (2Bh):
  - lw -> 5 cycles; EXE ext_op=01, alu_src=1; WB wd_sel=01, reg_dst=00.
  - sw -> 4 cycles; mem_wr=1 only in MEM, reg_wr never asserted.
- beq (04h):
  - zero=1 -> BR shows pc_wr=1, npc_op=01.
  - zero=0 -> pc_wr=0.
  - Both cases take 3 cycles.
- jal (03h) -> DCD shows pc_wr=1, npc_op=10, reg_wr=1, reg_dst=10, wd_sel=10; next state IF; CPI 2.
- Illegal op=3Fh:
  - ILLEGAL_TRAP=0 -> done in DCD, returns to IF, illegal=0.
  - ILLEGAL_TRAP=1 -> HALT, illegal=1 and all enables 0 for 10 cycles; reset clears both.
